// File: rtl/pulse_rx_pkg.sv
// Shared definitions for the pulse width receiver.
// Holds the receiver FSM state type and the level the synchronizer flops
// take in reset. The strobe line idles high, so resetting the chain to 1
// keeps a reset from looking like the start of a pulse.
package pulse_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOW  = 1'b1
    } rxStateT;

    localparam logic SYNC_RESET_LEVEL = 1'b1;

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
// Ports:
//   clk  - sampling clock
//   rstn - asynchronous active-low reset; every flop resets to the idle level
//   din  - asynchronous input
//   dout - synchronized output, STAGES clock edges behind din
module pulse_sync
    import pulse_rx_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // Plain shift chain; the first flop may go metastable, later ones settle it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {STAGES{SYNC_RESET_LEVEL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/pulse_width_receiver.sv
// Receiver for active-low strobe pulses from the delay-line pulse generator.
// Each pulse is synchronized, its low time measured in clk cycles, checked
// against a [minWidth, maxWidth] window and offered through a one-entry
// valid/ready result register.
// Ports:
//   clk, rstn      - clock and asynchronous active-low reset
//   enable         - arms detection; dropping it mid-pulse aborts the measurement
//   pulseN         - asynchronous active-low strobe, idles high
//   minWidth       - shortest legal width (inclusive), sampled at completion
//   maxWidth       - longest legal width (inclusive), sampled at completion
//   ready          - downstream accepts the current result
//   clearOverflow  - clears the sticky overflow flag
//   valid          - result register holds a result
//   width          - measured low time in cycles (saturating)
//   tooShort       - width < minWidth
//   tooLong        - width > maxWidth, or the counter saturated
//   eventCount     - completed pulses, including dropped ones (wraps)
//   overflow       - sticky, a completed result was dropped
module pulse_width_receiver
    import pulse_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH_BITS  = 4,
    parameter int CNT_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  pulseN,
    input  logic [WIDTH_BITS-1:0] minWidth,
    input  logic [WIDTH_BITS-1:0] maxWidth,
    input  logic                  ready,
    input  logic                  clearOverflow,
    output logic                  valid,
    output logic [WIDTH_BITS-1:0] width,
    output logic                  tooShort,
    output logic                  tooLong,
    output logic [CNT_BITS-1:0]   eventCount,
    output logic                  overflow
);

    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = '1;

    rxStateT               state;
    rxStateT               nextState;
    logic                  s;
    logic                  sPrev;
    logic [SYNC_STAGES:0]  warm;
    logic                  primed;
    logic                  falling;
    logic                  rising;
    logic                  complete;
    logic                  loadResult;
    logic                  dropResult;
    logic [WIDTH_BITS-1:0] widthCnt;
    logic                  satFlag;

    pulse_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .din (pulseN),
        .dout(s)
    );

    // sPrev holds the previous synchronized level for edge detection.
    // warm fills with ones after reset; until it is full, s and sPrev still
    // carry reset values rather than real samples. Gating edges on it means a
    // strobe that was already low when reset released is not mistaken for a
    // fresh falling edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sPrev <= SYNC_RESET_LEVEL;
            warm  <= '0;
        end else begin
            sPrev <= s;
            warm  <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign primed  = warm[SYNC_STAGES];
    assign falling = primed && !s && sPrev;
    assign rising  = primed && s && !sPrev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Losing enable in LOW takes priority over completion, so an abort
    // never produces a result or a count.
    always_comb begin
        nextState = state;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (falling && enable) begin
                    nextState = LOW;
                end
            end
            LOW: begin
                if (!enable) begin
                    nextState = IDLE;
                end else if (rising) begin
                    nextState = IDLE;
                    complete  = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign loadResult = complete && (!valid || ready);
    assign dropResult = complete && valid && !ready;

    // The falling-edge cycle counts as the first low cycle. satFlag marks a
    // pulse that stayed low after the counter had already reached its top.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            widthCnt <= '0;
            satFlag  <= 1'b0;
        end else if (state == IDLE && nextState == LOW) begin
            widthCnt <= WIDTH_BITS'(1);
            satFlag  <= 1'b0;
        end else if (state == LOW && enable && !s) begin
            if (widthCnt == WIDTH_MAX) begin
                satFlag <= 1'b1;
            end else begin
                widthCnt <= widthCnt + WIDTH_BITS'(1);
            end
        end
    end

    // One-entry result register; a pop and a push in the same cycle keep
    // valid high with the new contents.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid    <= 1'b0;
            width    <= '0;
            tooShort <= 1'b0;
            tooLong  <= 1'b0;
        end else if (loadResult) begin
            valid    <= 1'b1;
            width    <= widthCnt;
            tooShort <= (widthCnt < minWidth);
            tooLong  <= (widthCnt > maxWidth) || satFlag;
        end else if (valid && ready) begin
            valid    <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear leaves overflow set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eventCount <= '0;
            overflow   <= 1'b0;
        end else begin
            if (complete) begin
                eventCount <= eventCount + CNT_BITS'(1);
            end
            if (dropResult) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_receiver.sv
// Self-checking bench for pulse_width_receiver.
module tb_pulse_width_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int WIDTH_BITS  = 4;
    localparam int CNT_BITS    = 8;
    localparam int WMAX        = (1 << WIDTH_BITS) - 1;

    typedef struct packed {
        logic [WIDTH_BITS-1:0] w;
        logic                  ts;
        logic                  tl;
    } resT;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  enable;
    logic                  pulseN;
    logic [WIDTH_BITS-1:0] minWidth;
    logic [WIDTH_BITS-1:0] maxWidth;
    logic                  ready;
    logic                  clearOverflow;
    logic                  valid;
    logic [WIDTH_BITS-1:0] width;
    logic                  tooShort;
    logic                  tooLong;
    logic [CNT_BITS-1:0]   eventCount;
    logic                  overflow;

    int  tests    = 0;
    int  failures = 0;
    int  evExp    = 0;
    bit  randomReady = 1'b0;
    resT expQ[$];

    pulse_width_receiver #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH_BITS (WIDTH_BITS),
        .CNT_BITS   (CNT_BITS)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .pulseN       (pulseN),
        .minWidth     (minWidth),
        .maxWidth     (maxWidth),
        .ready        (ready),
        .clearOverflow(clearOverflow),
        .valid        (valid),
        .width        (width),
        .tooShort     (tooShort),
        .tooLong      (tooLong),
        .eventCount   (eventCount),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: width is the low-sample count clipped to the counter top;
    // anything longer than the top is always too long.
    function automatic resT model(input int n, input int mn, input int mx);
        resT r;
        int  w;
        w    = (n > WMAX) ? WMAX : n;
        r.w  = WIDTH_BITS'(w);
        r.ts = (w < mn);
        r.tl = (w > mx) || (n > WMAX);
        return r;
    endfunction

    // Every driven change happens on a falling clock edge.
    task automatic tick();
        @(negedge clk);
        if (randomReady) ready = 1'($urandom_range(0, 1));
    endtask

    // Low for exactly n rising edges, then back high.
    task automatic sendPulse(input int n);
        tick();
        pulseN = 1'b0;
        repeat (n) tick();
        pulseN = 1'b1;
    endtask

    task automatic applyStimulus(input int n, input bit expectResult);
        if (expectResult) expQ.push_back(model(n, int'(minWidth), int'(maxWidth)));
        sendPulse(n);
    endtask

    task automatic waitCount(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (int'(eventCount) == (evExp & ((1 << CNT_BITS) - 1))) break;
            tick();
        end
        #2;
        checkOutput(name, int'(eventCount), evExp & ((1 << CNT_BITS) - 1));
    endtask

    task automatic waitIdle(input string name);
        int i;
        for (i = 0; i < 300; i++) begin
            if (!valid) break;
            tick();
        end
        #2;
        checkOutput(name, int'(valid), 0);
    endtask

    // Monitor: a transfer is any cycle where valid and ready meet at the
    // coming rising edge; each one must match the oldest expected result.
    always @(negedge clk) begin
        #1;
        if (rstn && valid && ready) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious-result", 1, 0);
            end else begin
                resT e;
                e = expQ.pop_front();
                checkOutput("result-width", int'(width), int'(e.w));
                checkOutput("result-tooShort", int'(tooShort), int'(e.ts));
                checkOutput("result-tooLong", int'(tooLong), int'(e.tl));
            end
        end
    end

    initial begin
        rstn          = 1'b0;
        enable        = 1'b1;
        pulseN        = 1'b1;
        ready         = 1'b1;
        clearOverflow = 1'b0;
        minWidth      = 4'd2;
        maxWidth      = 4'd6;
        #23;
        checkOutput("reset-valid", int'(valid), 0);
        checkOutput("reset-width", int'(width), 0);
        checkOutput("reset-tooShort", int'(tooShort), 0);
        checkOutput("reset-tooLong", int'(tooLong), 0);
        checkOutput("reset-eventCount", int'(eventCount), 0);
        checkOutput("reset-overflow", int'(overflow), 0);
        tick();
        rstn = 1'b1;
        repeat (SYNC_STAGES + 3) tick();

        // Nominal and window edges
        applyStimulus(4, 1'b1);  evExp++; waitCount("count-nominal");  waitIdle("idle-nominal");
        applyStimulus(1, 1'b1);  evExp++; waitCount("count-short");    waitIdle("idle-short");
        applyStimulus(20, 1'b1); evExp++; waitCount("count-long");     waitIdle("idle-long");
        applyStimulus(15, 1'b1); evExp++; waitCount("count-top");      waitIdle("idle-top");
        applyStimulus(16, 1'b1); evExp++; waitCount("count-sat");      waitIdle("idle-sat");

        // Back-to-back pulses separated by a single high sample
        applyStimulus(3, 1'b1);
        applyStimulus(4, 1'b1);
        evExp += 2; waitCount("count-mingap"); waitIdle("idle-mingap");

        // Backpressure: first result held, second dropped
        ready = 1'b0;
        applyStimulus(3, 1'b1); evExp++; waitCount("count-bp1");
        repeat (2) tick();
        applyStimulus(5, 1'b0); evExp++; waitCount("count-bp2");
        checkOutput("bp-valid-held", int'(valid), 1);
        checkOutput("bp-width-held", int'(width), 3);
        checkOutput("bp-overflow", int'(overflow), 1);
        tick(); ready = 1'b1;
        tick(); #2;
        checkOutput("bp-valid-after-pop", int'(valid), 0);
        tick(); clearOverflow = 1'b1;
        tick(); clearOverflow = 1'b0; #2;
        checkOutput("bp-overflow-cleared", int'(overflow), 0);

        // Pop and push in the same cycle
        ready = 1'b0;
        applyStimulus(3, 1'b1); evExp++; waitCount("count-pp1");
        applyStimulus(6, 1'b1);
        repeat (SYNC_STAGES) tick();
        ready = 1'b1;
        tick(); #2;
        checkOutput("pp-valid-stays", int'(valid), 1);
        checkOutput("pp-no-overflow", int'(overflow), 0);
        evExp++; waitCount("count-pp2"); waitIdle("idle-pp");

        // enable dropped mid-pulse: aborted, not counted
        tick(); pulseN = 1'b0;
        repeat (SYNC_STAGES + 3) tick();
        enable = 1'b0;
        repeat (4) tick();
        pulseN = 1'b1;
        repeat (SYNC_STAGES + 3) tick();
        enable = 1'b1; #2;
        checkOutput("abort-count", int'(eventCount), evExp & 255);

        // enable low at the falling edge: ignored
        enable = 1'b0;
        applyStimulus(5, 1'b0);
        repeat (SYNC_STAGES + 3) tick();
        enable = 1'b1;
        repeat (3) tick(); #2;
        checkOutput("ignored-count", int'(eventCount), evExp & 255);
        checkOutput("ignored-valid", int'(valid), 0);

        // Randomized pulses, windows and backpressure
        randomReady = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            minWidth = WIDTH_BITS'($urandom_range(0, WMAX));
            maxWidth = WIDTH_BITS'($urandom_range(0, WMAX));
            applyStimulus(int'($urandom_range(1, 20)), 1'b1);
            evExp++;
            waitCount("count-random");
            waitIdle("idle-random");
            repeat ($urandom_range(1, 3)) tick();
        end
        randomReady = 1'b0;
        ready = 1'b1;
        minWidth = 4'd2;
        maxWidth = 4'd6;

        // Reset mid-pulse
        tick(); pulseN = 1'b0;
        repeat (SYNC_STAGES + 3) tick();
        #2 rstn = 1'b0;
        #1;
        evExp = 0;
        checkOutput("midreset-valid", int'(valid), 0);
        checkOutput("midreset-width", int'(width), 0);
        checkOutput("midreset-eventCount", int'(eventCount), 0);
        checkOutput("midreset-overflow", int'(overflow), 0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (6) tick();
        pulseN = 1'b1;
        repeat (10) tick(); #2;
        checkOutput("postreset-count", int'(eventCount), 0);
        checkOutput("postreset-valid", int'(valid), 0);

        // Recovery after reset
        applyStimulus(7, 1'b1); evExp++; waitCount("count-recover"); waitIdle("idle-recover");

        repeat (3) tick();
        checkOutput("queue-drained", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
